// File: rtl/wm8731_pkg.sv
// wm8731_pkg: shared WM8731 receiver constants, state encoding and frame-length helper
package wm8731_pkg;
  localparam int WM_DATA_W = 16;
  localparam int WM_FRAME_BITS = 2 * WM_DATA_W;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} rx_state_t;
  function automatic int frame_bits(input int dw);
    return 2 * dw;
  endfunction
endpackage

// File: rtl/wm8731_edge_sync.sv
// wm8731_edge_sync: pin input stage with registered rise/fall strobes; WM8731_ADC_RX_SYNC_EN selects a 2-flop synchroniser
module wm8731_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic rise,
  output logic fall,
  output logic dly
);
`ifdef WM8731_ADC_RX_SYNC_EN
  localparam int N = 2;
`else
  localparam int N = 1;
`endif
  logic [N-1:0] stage, stage_ok;
  logic cur, cur_ok, hist, hist_ok;
  assign cur = stage[N-1];
  assign cur_ok = stage_ok[N-1];
  // ok flags keep the refilling pipeline from faking an edge right after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '0;
      stage_ok <= '0;
      hist <= 1'b0;
      hist_ok <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      dly <= 1'b0;
    end else begin
      stage <= N'({stage, pin});
      stage_ok <= N'({stage_ok, 1'b1});
      hist <= cur;
      hist_ok <= cur_ok;
      rise <= cur_ok && hist_ok && cur && !hist;
      fall <= cur_ok && hist_ok && !cur && hist;
      dly <= cur;
    end
  end
endmodule

// File: rtl/wm8731_adc_rx.sv
// wm8731_adc_rx: WM8731 left-justified ADC frame receiver with valid/ready output; WM8731_ADC_RX_SYNC_EN adds pin synchronisers
module wm8731_adc_rx
  import wm8731_pkg::*;
#(
  parameter int DATA_W = WM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              b_clk,
  input  logic              adc_lr_clk,
  input  logic              adcdat,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err
);
  localparam int F = frame_bits(DATA_W);
  localparam int CW = $clog2(F + 1);
  logic lrc_rise, lrc_fall, lrc_dly;
  logic bck_rise, bck_fall, bck_dly;
  logic dat_rise, dat_fall, dat;
  logic unused;
  assign unused = ^{lrc_fall, lrc_dly, bck_rise, bck_dly, dat_rise, dat_fall};
  wm8731_edge_sync u_lrc (.clk(clk), .reset(reset), .pin(adc_lr_clk), .rise(lrc_rise), .fall(lrc_fall), .dly(lrc_dly));
  wm8731_edge_sync u_bck (.clk(clk), .reset(reset), .pin(b_clk), .rise(bck_rise), .fall(bck_fall), .dly(bck_dly));
  wm8731_edge_sync u_dat (.clk(clk), .reset(reset), .pin(adcdat), .rise(dat_rise), .fall(dat_fall), .dly(dat));
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [F-1:0] sr, sr_n;
  logic load;
  // LRC rise wins over a coincident b_clk fall: that fall's bit belongs to no frame
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    load = 1'b0;
    if (lrc_rise) begin
      state_n = SHIFT;
      cnt_n = '0;
    end else if (state == SHIFT && bck_fall) begin
      sr_n = {sr[F-2:0], dat};
      cnt_n = cnt + 1'b1;
      load = cnt == CW'(F - 1);
      state_n = load ? WAIT : SHIFT;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      left_data <= '0;
      right_data <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      frame_err <= lrc_rise && state == SHIFT;
      overrun <= load && sample_valid && !sample_ready;
      sample_valid <= load || (sample_valid && !sample_ready);
      if (load) {left_data, right_data} <= sr_n;
    end
  end
endmodule

// File: tb/tb_wm8731_adc_rx.sv
// tb_wm8731_adc_rx: codec-driven bench with a bit-queue reference model and directed plus random frames
module tb_wm8731_adc_rx;
`ifdef WM8731_ADC_RX_SYNC_EN
  localparam int LATS = 3;
`else
  localparam int LATS = 2;
`endif
  logic clk = 1'b0, reset = 1'b1, b_clk = 1'b1, adc_lr_clk = 1'b0, adcdat = 1'b0, sample_ready = 1'b1;
  logic [15:0] left_data, right_data;
  logic sample_valid, overrun, frame_err;
  wm8731_adc_rx #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .b_clk(b_clk), .adc_lr_clk(adc_lr_clk), .adcdat(adcdat),
    .left_data(left_data), .right_data(right_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .frame_err(frame_err)
  );
  always #10 clk = ~clk;
  int cyc = 0, n_chk = 0, n_pass = 0, t32 = 0, t_vrise = 0, n_ov = 0, n_fe = 0, n_vcyc = 0;
  bit rdy_k = 1'b0, rst_k = 1'b0, rnd_rdy = 1'b0, prev_v = 1'b0;
  bit in_frame = 1'b0;
  bit bits[$];
  logic [31:0] load_at[int];
  bit ferr_at[int];
  logic [15:0] m_l = '0, m_r = '0;
  bit m_v = 1'b0, m_ov = 1'b0, m_fe = 1'b0;
  always @(posedge clk) begin
    cyc++;
    rdy_k = sample_ready;
    rst_k = reset;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) sample_ready = 1'($urandom_range(0, 1));
  endtask
  // Codec-level view: bits captured since the last LRC rise; a frame completes at its 32nd capture
  task automatic model_fall(input bit lrc_up, input logic d);
    int t;
    logic [31:0] w;
    t = cyc + LATS + 1;
    if (lrc_up) begin
      if (in_frame && bits.size() < 32) ferr_at[t] = 1'b1;
      in_frame = 1'b1;
      bits.delete();
    end else if (in_frame && bits.size() < 32) begin
      bits.push_back(d);
      if (bits.size() == 32) begin
        w = '0;
        foreach (bits[k]) w[31-k] = bits[k];
        load_at[t] = w;
      end
    end
  endtask
  always @(negedge clk) begin
    bit ld;
    if (rst_k) begin
      {m_l, m_r, m_v, m_ov, m_fe} = '0;
    end else begin
      ld = load_at.exists(cyc);
      m_ov = ld && m_v && !rdy_k;
      m_v = ld || (m_v && !rdy_k);
      if (ld) {m_l, m_r} = load_at[cyc];
      m_fe = ferr_at.exists(cyc);
    end
    chk($sformatf("cycle %0d l/r/v/ov/fe", cyc), 64'({left_data, right_data, sample_valid, overrun, frame_err}),
        64'({m_l, m_r, m_v, m_ov, m_fe}));
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if (sample_valid) n_vcyc++;
    if (sample_valid && !prev_v) t_vrise = cyc;
    prev_v = sample_valid;
  end
  task automatic do_reset();
    reset = 1'b1;
    in_frame = 1'b0;
    bits.delete();
    load_at.delete();
    ferr_at.delete();
    tick();
    tick();
    chk("reset mid-frame outputs", 64'({left_data, right_data, sample_valid, overrun, frame_err}), 64'h0);
    reset = 1'b0;
  endtask
  // nb b_clk periods per frame; LRC rises with the first b_clk fall, data launches on b_clk rises
  task automatic frame(input logic [31:0] w, input int nb, input int rst_at);
    for (int i = 0; i < nb; i++) begin
      tick();
      model_fall(i == 0 && adc_lr_clk == 1'b0, adcdat);
      b_clk = 1'b0;
      adc_lr_clk = i < nb / 2;
      if (i == 32) t32 = cyc;
      repeat (7) tick();
      if (i == rst_at) do_reset();
      tick();
      b_clk = 1'b1;
      adcdat = i < 32 ? w[31-i] : 1'($urandom_range(0, 1));
      repeat (7) tick();
    end
  endtask
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int ov0, fe0;
    repeat (5) tick();
    chk("reset outputs", 64'({left_data, right_data, sample_valid, overrun, frame_err}), 64'h0);
    reset = 1'b0;
    repeat (10) tick();
    ov0 = n_ov; fe0 = n_fe; n_vcyc = 0;
    frame(32'hA5A53C3C, 34, -1);
    repeat (10) tick();
    chk("nominal left", 64'(left_data), 64'hA5A5);
    chk("nominal right", 64'(right_data), 64'h3C3C);
    chk("nominal valid cycles", 64'(n_vcyc), 64'd1);
    chk("nominal pulses", 64'((n_ov - ov0) + (n_fe - fe0)), 64'd0);
    chk("latency", 64'(t_vrise - t32), 64'(LATS + 1));
    sample_ready = 1'b0;
    ov0 = n_ov;
    frame(32'h12345678, 34, -1);
    frame(32'h9ABCDEF0, 34, -1);
    repeat (10) tick();
    chk("backpressure overrun count", 64'(n_ov - ov0), 64'd1);
    chk("backpressure left", 64'(left_data), 64'h9ABC);
    chk("backpressure right", 64'(right_data), 64'hDEF0);
    chk("backpressure valid held", 64'(sample_valid), 64'd1);
    sample_ready = 1'b1;
    tick();
    chk("valid cleared after accept", 64'(sample_valid), 64'd0);
    fe0 = n_fe;
    frame($urandom, 21, -1);
    frame(32'h00FF00FF, 34, -1);
    repeat (10) tick();
    chk("short frame_err count", 64'(n_fe - fe0), 64'd1);
    chk("after short left", 64'(left_data), 64'h00FF);
    chk("after short right", 64'(right_data), 64'h00FF);
    ov0 = n_ov; fe0 = n_fe;
    frame($urandom, 34, 11);
    frame(32'hFFFF0001, 34, -1);
    repeat (10) tick();
    chk("after reset left", 64'(left_data), 64'hFFFF);
    chk("after reset right", 64'(right_data), 64'h0001);
    chk("reset pulses", 64'((n_ov - ov0) + (n_fe - fe0)), 64'd0);
    fe0 = n_fe;
    frame(32'h80000001, 40, -1);
    chk("extra bits left", 64'(left_data), 64'h8000);
    chk("extra bits right", 64'(right_data), 64'h0001);
    frame($urandom, 34, -1);
    chk("extra bits no frame_err", 64'(n_fe - fe0), 64'd0);
    rnd_rdy = 1'b1;
    repeat (8) frame($urandom, $urandom_range(20, 40), -1);
    rnd_rdy = 1'b0;
    sample_ready = 1'b1;
    repeat (20) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
